// File: rtl/poly_decompress_ctrl.sv
// poly_decompress_ctrl: sequences a 96-byte packed 3-bit polynomial into 256 decompressed 12-bit coefficients.
// Optional `abort` input is compiled in when POLY_DECOMP_ABORT_EN is defined.
module poly_decompress_ctrl #(
    parameter int unsigned KYBER_Q = 3329,
    parameter int unsigned N_COEF  = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
`ifdef POLY_DECOMP_ABORT_EN
    input  logic        abort,
`endif
    output logic        busy,
    output logic        done,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] coef_data,
    output logic [7:0]  coef_addr,
    output logic        coef_valid,
    input  logic        coef_ready
);
    localparam int unsigned N_GROUPS = N_COEF / 8;
    localparam int unsigned GW       = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_UNPACK,
        S_EMIT,
        S_DONE
    } state_t;

    state_t        st, nxt;
    logic [1:0]    byte_cnt;
    logic [2:0]    lane;
    logic [GW-1:0] grp;
    logic [23:0]   word;
    logic [63:0]   lanes;
    logic          abort_req;
    logic          last_group;
    logic [7:0]    lane_byte;
    logic [14:0]   prod;
    logic [GW+2:0] addr_full;

`ifdef POLY_DECOMP_ABORT_EN
    assign abort_req = abort && (st != S_IDLE);
`else
    assign abort_req = 1'b0;
`endif

    assign last_group = (grp == GW'(N_GROUPS - 1));

    Poly_Decompress__t u_unpack (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (st == S_UNPACK),
        .word  (word),
        .lanes (lanes)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st <= S_IDLE;
        else        st <= nxt;
    end

    always_comb begin
        nxt        = st;
        busy       = (st != S_IDLE);
        in_ready   = (st == S_LOAD);
        coef_valid = (st == S_EMIT);
        done       = (st == S_DONE);
        case (st)
            S_IDLE:   if (start) nxt = S_LOAD;
            S_LOAD:   if (in_valid && byte_cnt == 2'd2) nxt = S_UNPACK;
            S_UNPACK: nxt = S_EMIT;
            S_EMIT:   if (coef_ready && lane == 3'd7) nxt = last_group ? S_DONE : S_LOAD;
            S_DONE:   nxt = S_IDLE;
            default:  nxt = S_IDLE;
        endcase
        // abort outranks everything, including a handshake in the same cycle
        if (abort_req) nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= '0;
            lane     <= '0;
            grp      <= '0;
            word     <= '0;
        end else if (abort_req) begin
            byte_cnt <= '0;
            lane     <= '0;
            grp      <= '0;
        end else begin
            case (st)
                S_LOAD: if (in_valid) begin
                    case (byte_cnt)
                        2'd0:    word[23:16] <= in_data;
                        2'd1:    word[15:8]  <= in_data;
                        default: word[7:0]   <= in_data;
                    endcase
                    byte_cnt <= (byte_cnt == 2'd2) ? '0 : byte_cnt + 2'd1;
                end
                S_UNPACK: lane <= '0;
                S_EMIT: if (coef_ready) begin
                    lane <= lane + 3'd1;
                    if (lane == 3'd7 && !last_group) grp <= grp + 1'b1;
                end
                S_DONE:  grp <= '0;
                default: ;
            endcase
        end
    end

    always_comb begin
        lane_byte = '0;
        for (int unsigned j = 0; j < 8; j++) begin
            if (lane == 3'(j)) lane_byte = lanes[63 - 8*j -: 8];
        end
        prod      = 15'(lane_byte & 8'h07) * 15'(KYBER_Q) + 15'd4;
        addr_full = {grp, lane};
        coef_data = coef_valid ? {4'b0000, 12'(prod >> 3)} : '0;
        coef_addr = coef_valid ? 8'(addr_full) : '0;
    end

endmodule

// Poly_Decompress__t: registers one 24-bit group and splits it into eight zero-extended 3-bit lanes.
// The group is little-endian across its bytes: lane 0 is the low 3 bits of the first byte received.
module Poly_Decompress__t (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [23:0] word,
    output logic [63:0] lanes
);
    logic [23:0] le;

    assign le = {word[7:0], word[15:8], word[23:16]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lanes <= '0;
        end else if (load) begin
            for (int unsigned j = 0; j < 8; j++) begin
                lanes[63 - 8*j -: 8] <= {5'b00000, le[3*j +: 3]};
            end
        end
    end

endmodule

// File: doc/poly_decompress_ctrl.md
# poly_decompress_ctrl

Sequencer for the 3-bit polynomial decompression path. It accepts the 96-byte packed polynomial as a byte stream and assembles each 3-byte group into a 24-bit word. It drives the registered 3-bit unpacker `Poly_Decompress__t`, an internal instance. It then serialises the eight unpacked lanes as decompressed 12-bit coefficients into polynomial RAM at addresses 0..255.

## Interface
Parameters:
- `KYBER_Q`, 3329: modulus used in decompression.
- `N_COEF`, 256: coefficients per polynomial. Must be a multiple of 8.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1: clock. All state updates on the rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `start`  in  1: one-cycle request to decompress one polynomial. Sampled only in IDLE.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse when the final coefficient has been accepted.
- `in_data`  in  8: packed byte.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: high only in LOAD.
- `coef_data`  out  16: decompressed coefficient, zero-extended from 12 bits.
- `coef_addr`  out  8: coefficient index.
- `coef_valid`  out  1: coefficient is valid. Held until accepted.
- `coef_ready`  in  1: sink accepts the coefficient.

## Operation
- States: IDLE, LOAD, UNPACK, EMIT, DONE.
- IDLE → LOAD on `start`.
- LOAD:
  - `in_ready`=1.
  - Each cycle with `in_valid`=1 stores one byte. Byte k of a group goes to bits [23-8k -: 8], so the first byte is the MSB.
  - A 2-bit byte counter is used. After the third byte is accepted → UNPACK.
- UNPACK:
  - Lasts one cycle. The unpacker registers the 24-bit word.
  - The lane index j is cleared. → EMIT.
- EMIT:
  - Lane j is taken from unpacker bits [63-8j -: 8] and masked to 3 bits as t.
  - `coef_data` = ((t·KYBER_Q)+4)>>3. This is computed in at least 15 bits; the result is ≤ 2913.
  - `coef_addr` = 8·g + j, where g is the group counter.
  - `coef_valid`=1. Advance j only on `coef_valid & coef_ready`.
  - After lane 7 is accepted: if g = N_COEF/8−1 → DONE; otherwise g+1 → LOAD.
- DONE: `done`=1 for one cycle. g is cleared. → IDLE.
- `start` while `busy`=1 is ignored. No queuing.
- `coef_data` and `coef_addr` must remain stable while `coef_valid`=1 and `coef_ready`=0.
- Bytes offered outside LOAD are not consumed, because `in_ready`=0.
- g wraps from 31 only through DONE → IDLE. No carry into the next polynomial.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0, byte and lane registers 0.
- `in_ready`, `busy`, `coef_valid` and `done` are decoded from registered state. None of them depends combinationally on `start`, `in_valid` or `coef_ready`.
- `start` sampled at edge E: `busy`=1 and `in_ready`=1 from E+1.
- Best case per group: 3 LOAD + 1 UNPACK + 8 EMIT = 12 cycles.
- Full polynomial best case: 384 cycles from the first LOAD cycle to the last coefficient handshake. `done` is asserted in the following cycle.
- Backpressure: each cycle with `coef_ready`=0 adds one cycle. Each cycle with `in_valid`=0 in LOAD adds one cycle.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0. Partial groups are discarded.

## Configuration
- `POLY_DECOMP_ABORT_EN`:
  - Defined: adds input port `abort` (1 bit). When `abort`=1 in any non-IDLE state, the next state is IDLE, counters are cleared, `coef_valid` is 0 and no `done` is produced. `abort` outranks every other transition, including a concurrent coefficient handshake.
  - Undefined: no `abort` port. Once started, the polynomial always runs to DONE.

## Test plan
- Reset, then `start` and 96 bytes of 0xFF with `coef_ready`=1 → 256 coefficients of 2913 at addr 0..255. `done` pulses exactly once, 1 cycle after the last handshake. Total run is 384 cycles.
- First group 0x88, 0xC6, 0xFA → addr 0..7 carry 0, 416, 832, 1248, 1665, 2081, 2497, 2913.
- All-zero input with `coef_ready` toggling randomly → 256 zeros. `coef_data` and `coef_addr` are stable during stalls. No duplicated or skipped address.
- `in_valid` held low for 5 cycles mid-group; `start` pulsed while busy → no byte is lost, the pulse is ignored, and the run's coefficient sequence and single `done` are unchanged. The run takes exactly 5 cycles longer.
- `rst_n` asserted during EMIT of group 10, then a fresh run → outputs are 0 immediately. The new run starts at addr 0 with correct data.
- With `POLY_DECOMP_ABORT_EN`: `abort` during LOAD of group 3 → IDLE next cycle, no `done`. The next `start` restarts at addr 0.
